dma_mem_endpoint: RTL and testbench

Memory-side endpoint of the DMA address-supported path: the slave that sits directly downstream of the DMA on its 4-bit memory port and address/length channel.
- Accepts one transfer descriptor (address, byte length, direction).
- cpu_to_mem: assembles incoming nibbles into bytes and writes them into a local byte RAM.
- mem_to_cpu: streams RAM bytes back out as nibbles.
- All channels use the DMA valid/enable handshake; a beat transfers when valid and enable are both 1 on a rising clock edge.

---
 rtl/dma_pkg.sv | 18 +
 rtl/dma_mem_endpoint_if.sv | 45 ++++
 rtl/dma_mem_ram.sv | 27 ++
 rtl/dma_mem_endpoint.sv | 117 +++++++++++
 tb/tb_dma_mem_endpoint.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared constants and state encoding for the DMA memory endpoint
// Purpose: direction codes, nibble/byte widths and the endpoint FSM state type.
package dma_pkg;

  localparam logic MODE_CPU_TO_MEM = 1'b1;
  localparam logic MODE_MEM_TO_CPU = 1'b0;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_FIN  = 2'd3
  } ep_state_t;

endpackage

// File: rtl/dma_mem_endpoint_if.sv
// rtl/dma_mem_endpoint_if.sv - descriptor and nibble channels between DMA and memory endpoint
// Purpose: bundles the descriptor channel, write nibble channel, read nibble channel
//          and status outputs of the endpoint.
// Ports (signals):
//   mode, addr_in_valid/addr_in_enable, addr_in, len_in  - descriptor channel
//   dma_to_mem_valid/dma_to_mem_enable, mem_in_socket    - write nibbles (DMA -> endpoint)
//   mem_to_dma_valid/mem_to_dma_enable, mem_out_socket   - read nibbles (endpoint -> DMA)
//   busy, done                                           - status
// Modports: master = DMA side, slave = endpoint side.
interface dma_mem_endpoint_if
  import dma_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 32
);

  logic                mode;
  logic                addr_in_valid;
  logic                addr_in_enable;
  logic [ADDR_W-1:0]   addr_in;
  logic [LEN_W-1:0]    len_in;
  logic                dma_to_mem_valid;
  logic                dma_to_mem_enable;
  logic [NIBBLE_W-1:0] mem_in_socket;
  logic                mem_to_dma_valid;
  logic                mem_to_dma_enable;
  logic [NIBBLE_W-1:0] mem_out_socket;
  logic                busy;
  logic                done;

  modport master (
    output mode, addr_in_valid, addr_in, len_in,
    output dma_to_mem_valid, mem_in_socket, mem_to_dma_enable,
    input  addr_in_enable, dma_to_mem_enable, mem_to_dma_valid, mem_out_socket,
    input  busy, done
  );

  modport slave (
    input  mode, addr_in_valid, addr_in, len_in,
    input  dma_to_mem_valid, mem_in_socket, mem_to_dma_enable,
    output addr_in_enable, dma_to_mem_enable, mem_to_dma_valid, mem_out_socket,
    output busy, done
  );

endinterface

// File: rtl/dma_mem_ram.sv
// rtl/dma_mem_ram.sv - byte RAM with synchronous write and asynchronous read
// Purpose: local storage of the endpoint; contents are never reset.
// Ports: clk; we/waddr/wdata write port (rising edge); raddr/rdata combinational read.
module dma_mem_ram
  import dma_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [BYTE_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [BYTE_W-1:0]     rdata
);

  logic [BYTE_W-1:0] r_mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dma_mem_endpoint.sv
// rtl/dma_mem_endpoint.sv - memory-side slave of the DMA nibble port
// Purpose: accepts one descriptor (address, byte length, direction), then either
//          assembles write nibbles into RAM bytes or streams RAM bytes out as nibbles.
// Ports: clk, resetn (async active-low); bus = dma_mem_endpoint_if.slave carrying
//        the descriptor, write-nibble, read-nibble channels and busy/done.
module dma_mem_endpoint
  import dma_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 32
) (
  input logic               clk,
  input logic               resetn,
  dma_mem_endpoint_if.slave bus
);

  ep_state_t             r_state;
  ep_state_t             w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [LEN_W-1:0]      r_rem;
  logic                  r_phase;
  logic [NIBBLE_W-1:0]   r_hold;

  logic                  w_desc_hs;
  logic                  w_wr_hs;
  logic                  w_rd_hs;
  logic                  w_byte_done;
  logic                  w_last;
  logic                  w_ram_we;
  logic [BYTE_W-1:0]     w_rdata;
  logic                  w_unused_addr;

  assign w_desc_hs   = (r_state == ST_IDLE) && bus.addr_in_valid;
  assign w_wr_hs     = (r_state == ST_WR) && bus.dma_to_mem_valid;
  assign w_rd_hs     = (r_state == ST_RD) && bus.mem_to_dma_enable;
  // A byte completes on the high-phase handshake in either direction.
  assign w_byte_done = (w_wr_hs || w_rd_hs) && r_phase;
  assign w_last      = w_byte_done && (r_rem == LEN_W'(1));
  assign w_ram_we    = w_wr_hs && r_phase;

  // Upper address bits select nothing inside the RAM.
  assign w_unused_addr = &{1'b0, bus.addr_in[ADDR_W-1:DEPTH_LOG2]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_desc_hs) begin
          if (bus.len_in == '0) begin
            w_state_nxt = ST_FIN;
          end else if (bus.mode == MODE_CPU_TO_MEM) begin
            w_state_nxt = ST_WR;
          end else begin
            w_state_nxt = ST_RD;
          end
        end
      end
      ST_WR:   if (w_last) w_state_nxt = ST_FIN;
      ST_RD:   if (w_last) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= '0;
      r_rem   <= '0;
      r_phase <= 1'b0;
      r_hold  <= '0;
    end else if (w_desc_hs) begin
      r_ptr   <= bus.addr_in[DEPTH_LOG2-1:0];
      r_rem   <= bus.len_in;
      r_phase <= 1'b0;
    end else if (w_wr_hs || w_rd_hs) begin
      r_phase <= ~r_phase;
      if (w_wr_hs && !r_phase) begin
        r_hold <= bus.mem_in_socket;
      end
      if (w_byte_done) begin
        r_ptr <= r_ptr + DEPTH_LOG2'(1);
        if (r_rem != '0) begin
          r_rem <= r_rem - LEN_W'(1);
        end
      end
    end
  end

  dma_mem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk  (clk),
    .we   (w_ram_we),
    .waddr(r_ptr),
    .wdata({bus.mem_in_socket, r_hold}),
    .raddr(r_ptr),
    .rdata(w_rdata)
  );

  assign bus.addr_in_enable    = (r_state == ST_IDLE);
  assign bus.dma_to_mem_enable = (r_state == ST_WR);
  assign bus.mem_to_dma_valid  = (r_state == ST_RD);
  assign bus.done              = (r_state == ST_FIN);
  assign bus.busy              = (r_state != ST_IDLE);
  assign bus.mem_out_socket    = (r_state != ST_RD) ? '0 :
                                 r_phase ? w_rdata[BYTE_W-1:NIBBLE_W] : w_rdata[NIBBLE_W-1:0];

endmodule

// File: tb/tb_dma_mem_endpoint.sv
// tb/tb_dma_mem_endpoint.sv - self-checking bench for dma_mem_endpoint
module tb_dma_mem_endpoint;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  dma_mem_endpoint_if #(.ADDR_W(32), .LEN_W(32)) bus ();

  dma_mem_endpoint #(.DEPTH_LOG2(8), .ADDR_W(32), .LEN_W(32)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // nibs holds the nibble stream with nibble i at bits [4i+3:4i], i.e. the
  // bytes in little-endian order.
  typedef struct packed {
    logic        mode;
    logic [31:0] addr;
    logic [31:0] len;
    logic [23:0] nibs;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_desc(input logic m, input logic [31:0] a, input logic [31:0] l);
    bus.mode          = m;
    bus.addr_in       = a;
    bus.len_in        = l;
    bus.addr_in_valid = 1'b1;
    check("desc_enable", 32'(bus.addr_in_enable), 32'd1);
    @(negedge clk);
    bus.addr_in_valid = 1'b0;
  endtask

  task automatic finish_xfer();
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_in_fin", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("idle_enable", 32'(bus.addr_in_enable), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    send_desc(v.mode, v.addr, v.len);
    for (int i = 0; i < 2 * int'(v.len); i++) begin
      if (v.mode) begin
        check("wr_enable", 32'(bus.dma_to_mem_enable), 32'd1);
        bus.dma_to_mem_valid = 1'b1;
        bus.mem_in_socket    = v.nibs[4*i +: 4];
      end else begin
        bus.mem_to_dma_enable = 1'b1;
        check("rd_valid", 32'(bus.mem_to_dma_valid), 32'd1);
        check("rd_nibble", 32'(bus.mem_out_socket), 32'(v.nibs[4*i +: 4]));
      end
      check("done_early", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    bus.dma_to_mem_valid  = 1'b0;
    bus.mem_to_dma_enable = 1'b0;
    finish_xfer();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr_en"}, 32'(bus.addr_in_enable), 32'd1);
    check({tag, "_wr_en"}, 32'(bus.dma_to_mem_enable), 32'd0);
    check({tag, "_rd_valid"}, 32'(bus.mem_to_dma_valid), 32'd0);
    check({tag, "_socket"}, 32'(bus.mem_out_socket), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [3:0]  bp_en;
    logic [19:0] bp_exp;
    logic [11:0] mr_nibs;

    n_vec = 0;
    n_err = 0;

    vecs[0] = '{mode: 1'b1, addr: 32'h10,  len: 32'd3, nibs: 24'h561234};
    vecs[1] = '{mode: 1'b0, addr: 32'h10,  len: 32'd3, nibs: 24'h561234};
    vecs[2] = '{mode: 1'b1, addr: 32'h1FF, len: 32'd2, nibs: 24'h00BBAA};
    vecs[3] = '{mode: 1'b0, addr: 32'h1FF, len: 32'd2, nibs: 24'h00BBAA};
    vecs[4] = '{mode: 1'b1, addr: 32'h20,  len: 32'd1, nibs: 24'h00000F};
    vecs[5] = '{mode: 1'b1, addr: 32'h31,  len: 32'd1, nibs: 24'h0000DC};
    vecs[6] = '{mode: 1'b0, addr: 32'h20,  len: 32'd1, nibs: 24'h00000F};
    vecs[7] = '{mode: 1'b0, addr: 32'h30,  len: 32'd2, nibs: 24'h00DC87};

    resetn                = 1'b0;
    bus.mode              = 1'b0;
    bus.addr_in_valid     = 1'b0;
    bus.addr_in           = '0;
    bus.len_in            = '0;
    bus.dma_to_mem_valid  = 1'b0;
    bus.mem_in_socket     = '0;
    bus.mem_to_dma_enable = 1'b0;

    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Write, read-back, wrap write/read, and prefill of bytes for later checks.
    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k]);
    end

    // Zero length: straight to FIN, stray write nibble ignored.
    bus.dma_to_mem_valid = 1'b1;
    bus.mem_in_socket    = 4'h9;
    send_desc(1'b1, 32'h20, 32'd0);
    check("zl_wr_en", 32'(bus.dma_to_mem_enable), 32'd0);
    finish_xfer();
    check("zl_wr_en_after", 32'(bus.dma_to_mem_enable), 32'd0);
    bus.dma_to_mem_valid = 1'b0;

    // Backpressure on the read side.
    bp_en  = 4'b0;
    bp_exp = 20'h33444;
    send_desc(1'b0, 32'h10, 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.mem_to_dma_enable = (i == 2 || i == 4);
      check("bp_valid", 32'(bus.mem_to_dma_valid), 32'd1);
      check("bp_nibble", 32'(bus.mem_out_socket), 32'(bp_exp[4*i +: 4]));
      check("bp_done_early", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    bus.mem_to_dma_enable = bp_en[0];
    finish_xfer();

    // Reset in the middle of a write: first byte kept, half byte discarded.
    mr_nibs = 12'h987;
    send_desc(1'b1, 32'h30, 32'd2);
    for (int i = 0; i < 3; i++) begin
      bus.dma_to_mem_valid = 1'b1;
      bus.mem_in_socket    = mr_nibs[4*i +: 4];
      @(negedge clk);
    end
    check("mr_busy_before", 32'(bus.busy), 32'd1);
    bus.dma_to_mem_valid = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_outputs("mr_async");
    @(negedge clk);
    check("mr_done_in_reset", 32'(bus.done), 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("mr_release");

    // Zero-length left 0x20 intact; reset left 0x30 written and 0x31 untouched.
    for (int k = 6; k < 8; k++) begin
      run_vec(vecs[k]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
